// File: rtl/display_arbiter.sv
// Round-robin arbiter that lends one seven-segment display to NUM_REQ requesters,
// with a guaranteed minimum tenure of HOLD_CYCLES before a waiting requester can preempt.
module display_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [4*NUM_REQ-1:0]   req_value,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic [6:0]             display_0
);

    localparam int               IDX_W    = $clog2(NUM_REQ);
    localparam int               CNT_W    = $clog2(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);
    localparam logic [6:0]       BLANK    = 7'b1111111;
    localparam logic [NUM_REQ-1:0] ONE    = NUM_REQ'(1);

    typedef enum logic {IDLE, GRANT} state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    state_t             state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic               busy_q;
    logic [6:0]         disp_q;
    logic [CNT_W-1:0]   hold_q;
    logic [IDX_W-1:0]   last_q;
    logic [IDX_W-1:0]   owner_q;

    logic [3:0]         nib [NUM_REQ];
    logic [IDX_W-1:0]   winner_d;
    logic [IDX_W-1:0]   cand;
    logic               found_d;
    logic               others_req;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            nib[i] = req_value[4*i +: 4];
        end
    end

    // Search starts just after the previous owner so every requester gets a turn.
    always_comb begin
        winner_d = '0;
        found_d  = 1'b0;
        cand     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_q) + k) % NUM_REQ);
            if (!found_d && req[cand]) begin
                winner_d = cand;
                found_d  = 1'b1;
            end
        end
    end

    assign others_req = |(req & ~grant_q);

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            disp_q  <= BLANK;
            hold_q  <= '0;
            last_q  <= LAST_RST;
            owner_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        state_q <= GRANT;
                        grant_q <= ONE << winner_d;
                        busy_q  <= 1'b1;
                        last_q  <= winner_d;
                        owner_q <= winner_d;
                        hold_q  <= '0;
                        disp_q  <= seg_decode(nib[winner_d]);
                    end else begin
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        disp_q  <= BLANK;
                    end
                end
                default: begin
                    // Release has priority over preempt; both land in IDLE for one blank cycle.
                    if (!req[owner_q] || (hold_q == HOLD_MAX && others_req)) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        disp_q  <= BLANK;
                    end else begin
                        if (hold_q != HOLD_MAX) begin
                            hold_q <= hold_q + 1'b1;
                        end
                        disp_q <= seg_decode(nib[owner_q]);
                    end
                end
            endcase
        end
    end

    assign grant     = grant_q;
    assign busy      = busy_q;
    assign display_0 = disp_q;

endmodule
